// File: rtl/alu_share_arbiter_if.sv
// Handshake and ALU-drive bundle for alu_share_arbiter.
// master = requesters plus ALU instance, slave = the arbiter itself.
interface alu_share_arbiter_if #(
    parameter int W    = 32,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_result;
    logic              rsp_overflow;
    logic              rsp_err;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [2:0]        alu_op;
    logic [W-1:0]      alu_result;
    logic              alu_overflow;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        output alu_result, alu_overflow,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_err,
        input  alu_a, alu_b, alu_op
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        input  alu_result, alu_overflow,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_err,
        output alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU among NREQ issue ports.
// One transaction in flight: IDLE (accept) -> EXEC (settle) -> RESP.
module alu_share_arbiter #(
    parameter int W    = 32,
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    alu_share_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   gnt_q;
    logic [2:0]      op_q;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic [2:0]      alu_op_q;
    logic [W-1:0]    result_q;
    logic            ovf_q;
    logic            err_q;
    logic [NREQ-1:0] rsp_valid_q;

    logic [IW-1:0]   win;
    logic            found;
    logic [31:0]     idx;
    logic [2:0]      win_op;
    logic [W-1:0]    win_a;
    logic [W-1:0]    win_b;

    // Pick the first valid requester after the last one served, wrapping.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + 32'(k)) % 32'(NREQ);
            if (!found && bus.req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    // Operands of the current round-robin winner.
    always_comb begin
        win_op = bus.req_op[win*3 +: 3];
        win_a  = bus.req_a[win*W +: W];
        win_b  = bus.req_b[win*W +: W];
    end

    // Accept strobe: only in IDLE, only for the winner, never under reset.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && found && !reset) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_err      = err_q;

    // Transaction FSM with registered ALU drive and response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= IW'(NREQ - 1);
            gnt_q       <= '0;
            op_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        gnt_q <= win;
                        op_q  <= win_op;
                        // Illegal ops leave the ALU ports untouched.
                        if (win_op <= OP_SUB) begin
                            alu_a_q  <= win_a;
                            alu_b_q  <= win_b;
                            alu_op_q <= win_op;
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q > OP_SUB) begin
                        result_q <= '0;
                        ovf_q    <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        result_q <= bus.alu_result;
                        ovf_q    <= bus.alu_overflow &&
                                    (op_q == OP_ADD || op_q == OP_SUB);
                        err_q    <= 1'b0;
                    end
                    rsp_valid_q        <= '0;
                    rsp_valid_q[gnt_q] <= 1'b1;
                    state_q            <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[gnt_q]) begin
                        last_q      <= gnt_q;
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
